display_scan_ctl: RTL and testbench

Time-multiplexed scan controller for an 8-digit common-anode seven-segment display. It sits directly upstream of the extended seven-segment decoder. Each cycle it presents one 7-bit extended digit code (d_out) to the decoder and drives the matching active-low anode. It holds a double-buffered digit frame that is reloaded only at frame boundaries through a req/ack handshake, so a partially updated frame is never displayed.

---
 rtl/display_scan_ctl.sv | 136 +++++++++++++
 tb/tb_display_scan_ctl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctl.sv
// display_scan_ctl
// Time-multiplexed scan controller for an 8-digit common-anode seven-segment
// display. It feeds one 7-bit extended digit code per scan slot to the
// downstream decoder and drives the matching active-low anode.
//
// Each digit slot is BLANK_CYC cycles with all anodes off, then SCAN_DIV
// cycles with that digit's anode on. d_out changes only on entry to BLANK,
// so the decoder input has settled before its anode lights.
//
// Digit codes are double-buffered: a shadow frame is reloaded from d0..d7
// only at the frame boundary, so a partially updated frame is never shown.
//
// Update handshake (level request / pulse acknowledge):
//   The requester raises upd_req and holds d0..d7 stable until upd_ack.
//   upd_req is looked at only on the frame-boundary edge (leaving SHOW of
//   digit 7). If it is high there, all eight codes are captured on that edge
//   and upd_ack pulses for exactly one cycle, together with frame_tick.
//   A request withdrawn before the boundary captures nothing and gets no ack.
//   A request held high is serviced at every boundary.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   d0..d7     extended digit codes ([6] blank, [5] dp, [4] dash, [3:0] hex);
//              d0 is the rightmost digit
//   upd_req    level request to load d0..d7
//   upd_ack    one-cycle pulse: d0..d7 captured on this edge
//   d_out      code of the current digit, to the decoder
//   an_n       active-low anode enables, one-hot-low during SHOW
//   frame_tick one-cycle pulse on the first cycle of each frame
//   scan_state current scan state (0 = BLANK, 1 = SHOW), for observation

module display_scan_ctl #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] d0,
  input  logic [6:0] d1,
  input  logic [6:0] d2,
  input  logic [6:0] d3,
  input  logic [6:0] d4,
  input  logic [6:0] d5,
  input  logic [6:0] d6,
  input  logic [6:0] d7,
  input  logic       upd_req,
  output logic       upd_ack,
  output logic [6:0] d_out,
  output logic [7:0] an_n,
  output logic       frame_tick,
  output logic       scan_state
);

  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CW      = $clog2(CNT_MAX);

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);

  localparam logic ST_BLANK = 1'b0;
  localparam logic ST_SHOW  = 1'b1;

  localparam logic [6:0] CODE_BLANK = 7'h40;

  logic          state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [2:0]    next_idx;
  logic [6:0]    shadow [8];
  logic [6:0]    din    [8];

  always_comb begin
    din[0] = d0;
    din[1] = d1;
    din[2] = d2;
    din[3] = d3;
    din[4] = d4;
    din[5] = d5;
    din[6] = d6;
    din[7] = d7;
  end

  // 3-bit increment wraps 7 -> 0 on its own.
  assign next_idx   = idx + 3'd1;
  assign scan_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) shadow[k] <= CODE_BLANK;
      d_out      <= CODE_BLANK;
      an_n       <= 8'hFF;
      idx        <= 3'd0;
      state      <= ST_BLANK;
      cnt        <= '0;
      upd_ack    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      upd_ack    <= 1'b0;
      frame_tick <= 1'b0;
      case (state)
        ST_BLANK: begin
          if (cnt == BLANK_LAST) begin
            cnt   <= '0;
            state <= ST_SHOW;
            an_n  <= ~(8'b1 << idx);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          if (cnt == SHOW_LAST) begin
            cnt   <= '0;
            idx   <= next_idx;
            state <= ST_BLANK;
            an_n  <= 8'hFF;
            d_out <= shadow[next_idx];
            if (idx == 3'd7) begin
              // Frame boundary: the only edge on which upd_req matters.
              frame_tick <= 1'b1;
              if (upd_req) begin
                for (int k = 0; k < 8; k++) shadow[k] <= din[k];
                upd_ack <= 1'b1;
                // Digit 0 of the new frame shows the freshly captured code.
                d_out   <= din[0];
              end
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_scan_ctl.sv
module tb_display_scan_ctl;

  localparam int SD     = 4;
  localparam int BC     = 2;
  localparam int SLOT   = SD + BC;
  localparam int FRAME  = 8 * SLOT;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [6:0] din [8];
  logic       upd_req;
  logic       upd_ack;
  logic [6:0] d_out;
  logic [7:0] an_n;
  logic       frame_tick;
  logic       scan_state;

  display_scan_ctl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .d0        (din[0]),
    .d1        (din[1]),
    .d2        (din[2]),
    .d3        (din[3]),
    .d4        (din[4]),
    .d5        (din[5]),
    .d6        (din[6]),
    .d7        (din[7]),
    .upd_req   (upd_req),
    .upd_ack   (upd_ack),
    .d_out     (d_out),
    .an_n      (an_n),
    .frame_tick(frame_tick),
    .scan_state(scan_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  // {scan_state, upd_ack, frame_tick, an_n, d_out}
  logic [17:0] exp_q[$];

  // Reference model: position in the scan timeline since reset.
  int         m_p;
  logic [6:0] m_shadow [8];

  int ack_cnt  = 0;
  int tick_cnt = 0;

  logic [7:0] seen_an   [128];
  logic [6:0] seen_d    [128];
  logic       seen_tick [128];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One clock cycle: predict the outputs after the coming edge from the
  // inputs now applied, let the edge happen, then compare on the falling edge.
  task automatic tick();
    logic [17:0] e;
    logic [17:0] got;
    logic [7:0]  one;
    logic        e_ack;
    int ph, dg;
    one   = 8'b1;
    e_ack = 1'b0;
    if (!rst_n) begin
      m_p = 0;
      for (int k = 0; k < 8; k++) m_shadow[k] = 7'h40;
    end else begin
      m_p++;
      if ((m_p % FRAME) == 0 && upd_req) begin
        for (int k = 0; k < 8; k++) m_shadow[k] = din[k];
        e_ack = 1'b1;
      end
    end
    ph = m_p % SLOT;
    dg = (m_p / SLOT) % 8;
    e = {(ph >= BC), e_ack, (m_p != 0 && (m_p % FRAME) == 0),
         (ph < BC) ? 8'hFF : ~(one << dg), m_shadow[dg]};
    exp_q.push_back(e);

    @(posedge clk);
    @(negedge clk);

    got = {scan_state, upd_ack, frame_tick, an_n, d_out};
    chk("cycle_outputs", got, exp_q.pop_front());
    checks++;
    if ($countones(~an_n) > 1) begin
      errors++;
      $display("FAIL anode_onehot: got an_n %0h expected at most one low bit", an_n);
    end
    if (upd_ack === 1'b1)    ack_cnt++;
    if (frame_tick === 1'b1) tick_cnt++;
    if (m_p < 128) begin
      seen_an[m_p]   = an_n;
      seen_d[m_p]    = d_out;
      seen_tick[m_p] = frame_tick;
    end
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 1000 && m_p < target; i++) tick();
  endtask

  // ---------------- spot-check table for the first frames ----------------
  typedef struct {
    int         p;
    logic [7:0] an;
    logic [6:0] d;
    logic       tk;
  } vec_t;

  vec_t vecs[15];

  int a0, t0;
  logic [6:0] v;

  initial begin
    vecs[0]  = '{0,  8'hFF, 7'h40, 1'b0};
    vecs[1]  = '{1,  8'hFF, 7'h40, 1'b0};
    vecs[2]  = '{2,  8'hFE, 7'h40, 1'b0};
    vecs[3]  = '{5,  8'hFE, 7'h40, 1'b0};
    vecs[4]  = '{6,  8'hFF, 7'h40, 1'b0};
    vecs[5]  = '{7,  8'hFF, 7'h40, 1'b0};
    vecs[6]  = '{8,  8'hFD, 7'h40, 1'b0};
    vecs[7]  = '{11, 8'hFD, 7'h40, 1'b0};
    vecs[8]  = '{44, 8'h7F, 7'h40, 1'b0};
    vecs[9]  = '{47, 8'h7F, 7'h40, 1'b0};
    vecs[10] = '{48, 8'hFF, 7'h40, 1'b1};
    vecs[11] = '{49, 8'hFF, 7'h40, 1'b0};
    vecs[12] = '{50, 8'hFE, 7'h40, 1'b0};
    vecs[13] = '{96, 8'hFF, 7'h40, 1'b1};
    vecs[14] = '{97, 8'hFF, 7'h40, 1'b0};

    rst_n   = 1'b0;
    upd_req = 1'b0;
    for (int k = 0; k < 8; k++) din[k] = 7'h00;
    m_p = 0;

    // Reset held for three cycles.
    repeat (3) tick();
    chk("rst_an_n", an_n, 8'hFF);
    chk("rst_d_out", d_out, 7'h40);
    chk("rst_ack", upd_ack, 1'b0);
    chk("rst_tick", frame_tick, 1'b0);

    // Free-running scan, then compare the recorded timeline to the table.
    rst_n = 1'b1;
    run_to(100);
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("scan_an_p%0d", vecs[i].p), seen_an[vecs[i].p], vecs[i].an);
      chk($sformatf("scan_d_p%0d", vecs[i].p), seen_d[vecs[i].p], vecs[i].d);
      chk($sformatf("scan_tick_p%0d", vecs[i].p), seen_tick[vecs[i].p], vecs[i].tk);
    end

    // Update at the frame boundary.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    run_to(10);
    for (int k = 0; k < 8; k++) din[k] = 7'(k);
    upd_req = 1'b1;
    a0 = ack_cnt;
    run_to(47);
    chk("upd_no_early_ack", ack_cnt - a0, 0);
    chk("upd_d_out_before", d_out, 7'h40);
    run_to(48);
    chk("upd_ack", upd_ack, 1'b1);
    chk("upd_tick", frame_tick, 1'b1);
    chk("upd_d0_now", d_out, 7'h00);
    upd_req = 1'b0;
    run_to(68);
    chk("upd_digit3_an", an_n, 8'hF7);
    chk("upd_digit3_d", d_out, 7'h03);
    a0 = ack_cnt;
    run_to(96);
    chk("upd_dropped_no_ack", ack_cnt - a0, 0);

    // Aborted request: high for frame cycles 20..30 only.
    run_to(116);
    din[3]  = 7'h0A;
    upd_req = 1'b1;
    a0 = ack_cnt;
    run_to(126);
    upd_req = 1'b0;
    run_to(212);
    chk("abort_no_ack", ack_cnt - a0, 0);
    chk("abort_digit3_an", an_n, 8'hF7);
    chk("abort_digit3_d", d_out, 7'h03);

    // Pass-through of dp and dash codes.
    din[3] = 7'h03;
    din[2] = 7'h25;
    din[5] = 7'h10;
    run_to(230);
    upd_req = 1'b1;
    run_to(240);
    chk("pass_ack", upd_ack, 1'b1);
    upd_req = 1'b0;
    for (int p = 252; p <= 257; p++) begin
      run_to(p);
      chk($sformatf("pass_d2_p%0d", p), d_out, 7'h25);
    end
    for (int p = 270; p <= 275; p++) begin
      run_to(p);
      chk($sformatf("pass_d5_p%0d", p), d_out, 7'h10);
    end

    // Reset in the middle of digit 3 SHOW.
    run_to(309);
    chk("mid_rst_pre_an", an_n, 8'hF7);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_an", an_n, 8'hFF);
    chk("mid_rst_d", d_out, 7'h40);
    chk("mid_rst_state", scan_state, 1'b0);
    rst_n = 1'b1;
    run_to(14);
    chk("mid_rst_lost_an", an_n, 8'hFB);
    chk("mid_rst_lost_d", d_out, 7'h40);

    // Continuous request with d0 changing each frame.
    upd_req = 1'b1;
    a0 = ack_cnt;
    t0 = tick_cnt;
    for (int f = 1; f <= 3; f++) begin
      run_to(FRAME * f - 10);
      v = 7'($urandom_range(0, 127));
      din[0] = v;
      run_to(FRAME * f);
      chk($sformatf("cont_ack_f%0d", f), upd_ack, 1'b1);
      chk($sformatf("cont_tick_f%0d", f), frame_tick, 1'b1);
      chk($sformatf("cont_d0_f%0d", f), d_out, v);
    end
    chk("cont_ack_count", ack_cnt - a0, 3);
    chk("cont_tick_count", tick_cnt - t0, 3);
    upd_req = 1'b0;
    run_to(FRAME * 3 + 8);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
